draw_rect: RTL and testbench



---
 rtl/vga_pkg.sv | 12 +
 rtl/draw_rect_if.sv | 40 ++++
 rtl/draw_rect_delay.sv | 31 +++
 rtl/draw_rect.sv | 123 ++++++++++++
 tb/tb_draw_rect.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA draw chain: counter/colour widths and the
// visible frame size. Every stage in the pipeline imports this package.
package vga_pkg;

    localparam int CNT_W      = 11;                // hcount/vcount width
    localparam int RGB_W      = 12;                // 4:4:4 colour width
    localparam int POS_W      = 12;                // rectangle position width
    localparam int HOR_PIXELS = 1024;              // visible pixels per line
    localparam int VER_PIXELS = 768;               // visible lines per frame
    localparam int TIMING_W   = 2 * CNT_W + 4;     // hcount + vcount + 4 flags

endpackage

// File: rtl/draw_rect_if.sv
// Pixel-stream bundle around draw_rect: position from draw_rect_ctl,
// incoming timing/colour, and the delayed timing/colour going downstream.
// There is no handshake: one pixel moves per clock, every clock.
interface draw_rect_if;
    import vga_pkg::*;

    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;

    logic [CNT_W-1:0] hcount_in;
    logic [CNT_W-1:0] vcount_in;
    logic             hsync_in;
    logic             vsync_in;
    logic             hblnk_in;
    logic             vblnk_in;
    logic [RGB_W-1:0] rgb_in;

    logic [CNT_W-1:0] hcount_out;
    logic [CNT_W-1:0] vcount_out;
    logic             hsync_out;
    logic             vsync_out;
    logic             hblnk_out;
    logic             vblnk_out;
    logic [RGB_W-1:0] rgb_out;

    // The draw stage consumes the *_in side and produces the *_out side.
    modport slave (
        input  xpos, ypos,
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );

    // The upstream stage (or a bench) drives the *_in side.
    modport master (
        output xpos, ypos,
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );

endinterface

// File: rtl/draw_rect_delay.sv
// Generic register chain: dout is din delayed by CLK_DEL clocks (CLK_DEL >= 1).
// Asynchronous active-high reset clears every stage.
module delay #(
    parameter int WIDTH   = 26,
    parameter int CLK_DEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [CLK_DEL];

    // Shift din through CLK_DEL registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect.sv
// Overlays a fixed-size solid rectangle onto the VGA pixel stream.
// Position is latched once per frame on the rising edge of vblank so the
// rectangle never tears; timing signals pass through a 2-cycle delay so they
// stay aligned with the recoloured pixels.
module draw_rect
    import vga_pkg::*;
#(
    parameter int               RECT_WIDTH  = 48,
    parameter int               RECT_HEIGHT = 64,
    parameter logic [RGB_W-1:0] RECT_COLOR  = 12'hF0F
) (
    input  logic       clk,
    input  logic       rst,
    draw_rect_if.slave bus
);

    // Frame latch state.
    logic             vblnk_prev_q;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;

    // Pipeline stage 1 and 2 colour path.
    logic [RGB_W-1:0] rgb_s1_q;
    logic             inside_s1_q;
    logic             blank_s1_q;
    logic             inside_d;
    logic             blank_d;
    logic [RGB_W-1:0] rgb_s2_q, rgb_s2_d;

    // 13-bit hit-test operands: position + size cannot wrap back to the origin.
    logic [12:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;

    logic [TIMING_W-1:0] timing_in, timing_out;

    // Capture a new position only on the vblank rising edge.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (bus.vblnk_in && !vblnk_prev_q) begin
            x_d = bus.xpos;
            y_d = bus.ypos;
        end
    end

    // Frame latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            vblnk_prev_q <= bus.vblnk_in;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    assign h_ext = {2'b00, bus.hcount_in};
    assign v_ext = {2'b00, bus.vcount_in};
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};
    assign x_end = x_ext + 13'(RECT_WIDTH);
    assign y_end = y_ext + 13'(RECT_HEIGHT);

    // Hit test against the latched rectangle, plus the combined blanking flag.
    always_comb begin
        inside_d = (h_ext >= x_ext) && (h_ext < x_end) &&
                   (v_ext >= y_ext) && (v_ext < y_end);
        blank_d  = bus.hblnk_in | bus.vblnk_in;
    end

    // Stage 1: register upstream colour and the per-pixel decisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_s1_q    <= '0;
            inside_s1_q <= 1'b0;
            blank_s1_q  <= 1'b0;
        end else begin
            rgb_s1_q    <= bus.rgb_in;
            inside_s1_q <= inside_d;
            blank_s1_q  <= blank_d;
        end
    end

    // Colour select: blanking wins, then the rectangle, then the background.
    always_comb begin
        rgb_s2_d = rgb_s1_q;
        if (blank_s1_q) begin
            rgb_s2_d = '0;
        end else if (inside_s1_q) begin
            rgb_s2_d = RECT_COLOR;
        end
    end

    // Stage 2: output colour register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_s2_q <= '0;
        end else begin
            rgb_s2_q <= rgb_s2_d;
        end
    end

    assign bus.rgb_out = rgb_s2_q;

    // Timing signals ride a matching 2-cycle chain, unmodified.
    assign timing_in = {bus.hcount_in, bus.vcount_in,
                        bus.hsync_in, bus.vsync_in, bus.hblnk_in, bus.vblnk_in};

    delay #(
        .WIDTH   (TIMING_W),
        .CLK_DEL (2)
    ) u_timing_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (timing_in),
        .dout (timing_out)
    );

    assign {bus.hcount_out, bus.vcount_out,
            bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out} = timing_out;

endmodule

// File: tb/tb_draw_rect.sv
// Bench for draw_rect: reset behaviour, a table of streamed pixels with
// hand-computed colours (one pixel per clock, checked two clocks later), and
// a line-long alignment sequence with an expected queue.
module tb_draw_rect;
    import vga_pkg::*;

    logic clk;
    logic rst;

    draw_rect_if bus ();

    draw_rect #(
        .RECT_WIDTH  (48),
        .RECT_HEIGHT (64),
        .RECT_COLOR  (12'hF0F)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;

    typedef struct {
        logic [11:0] xp;
        logic [11:0] yp;
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[$];
    logic [37:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        bus.xpos      = v.xp;
        bus.ypos      = v.yp;
        bus.hcount_in = v.h;
        bus.vcount_in = v.v;
        bus.hsync_in  = v.h[3];
        bus.vsync_in  = v.v[0];
        bus.hblnk_in  = v.hb;
        bus.vblnk_in  = v.vb;
        bus.rgb_in    = v.rgb;
    endtask

    task automatic drive_idle();
        vec_t v;
        v = '{xp: 12'd0, yp: 12'd0, h: 11'd0, v: 11'd0, hb: 1'b0, vb: 1'b0,
              rgb: 12'h000, exp_rgb: 12'h000};
        drive(v);
    endtask

    task automatic add_vec(input logic [11:0] xp, input logic [11:0] yp,
                           input logic [10:0] h, input logic [10:0] v,
                           input logic hb, input logic vb,
                           input logic [11:0] rgb, input logic [11:0] exp_rgb);
        vec_t e;
        e = '{xp: xp, yp: yp, h: h, v: v, hb: hb, vb: vb, rgb: rgb, exp_rgb: exp_rgb};
        vecs.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rgb_out"}, 64'(bus.rgb_out), 64'h0);
        check({tag, " timing_out"},
              64'({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
                   bus.hblnk_out, bus.vblnk_out}), 64'h0);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t e;
        vec_t a;
        int   n;
        logic [37:0] exp_w;
        logic [11:0] r;

        checks = 0;
        errors = 0;

        // Stream table: one entry per clock. Rectangle is 48x64, colour F0F.
        // Phase A: first vblank edge latches (0,0).
        add_vec(12'd0,    12'd0,   11'd0,    11'd0,    1'b0, 1'b1, 12'h5A5, 12'h000); // 0
        add_vec(12'd0,    12'd0,   11'd0,    11'd0,    1'b0, 1'b0, 12'h123, 12'hF0F); // 1
        add_vec(12'd0,    12'd0,   11'd47,   11'd63,   1'b0, 1'b0, 12'h123, 12'hF0F); // 2
        add_vec(12'd0,    12'd0,   11'd48,   11'd0,    1'b0, 1'b0, 12'h456, 12'h456); // 3
        add_vec(12'd0,    12'd0,   11'd0,    11'd64,   1'b0, 1'b0, 12'h456, 12'h456); // 4
        // Phase B: new position (100,50) waits for vblank.
        add_vec(12'd100,  12'd50,  11'd10,   11'd10,   1'b0, 1'b0, 12'h111, 12'hF0F); // 5
        add_vec(12'd100,  12'd50,  11'd0,    11'd770,  1'b0, 1'b1, 12'h222, 12'h000); // 6
        add_vec(12'd100,  12'd50,  11'd1,    11'd771,  1'b0, 1'b1, 12'h222, 12'h000); // 7
        add_vec(12'd100,  12'd50,  11'd100,  11'd50,   1'b0, 1'b0, 12'h333, 12'hF0F); // 8
        add_vec(12'd100,  12'd50,  11'd147,  11'd113,  1'b0, 1'b0, 12'h333, 12'hF0F); // 9
        add_vec(12'd100,  12'd50,  11'd99,   11'd50,   1'b0, 1'b0, 12'h444, 12'h444); // 10
        add_vec(12'd100,  12'd50,  11'd148,  11'd50,   1'b0, 1'b0, 12'h555, 12'h555); // 11
        add_vec(12'd100,  12'd50,  11'd147,  11'd114,  1'b0, 1'b0, 12'h666, 12'h666); // 12
        add_vec(12'd100,  12'd50,  11'd120,  11'd60,   1'b1, 1'b0, 12'h777, 12'h000); // 13
        add_vec(12'd100,  12'd50,  11'd120,  11'd60,   1'b0, 1'b0, 12'h777, 12'hF0F); // 14
        // Mid-frame xpos change to 300: still drawn at x=100 until vblank.
        add_vec(12'd300,  12'd50,  11'd100,  11'd200,  1'b0, 1'b0, 12'h888, 12'h888); // 15
        add_vec(12'd300,  12'd50,  11'd100,  11'd60,   1'b0, 1'b0, 12'h999, 12'hF0F); // 16
        add_vec(12'd300,  12'd50,  11'd300,  11'd60,   1'b0, 1'b0, 12'h999, 12'h999); // 17
        add_vec(12'd300,  12'd50,  11'd0,    11'd770,  1'b0, 1'b1, 12'h999, 12'h000); // 18
        add_vec(12'd300,  12'd50,  11'd300,  11'd50,   1'b0, 1'b0, 12'hAAA, 12'hF0F); // 19
        add_vec(12'd300,  12'd50,  11'd100,  11'd50,   1'b0, 1'b0, 12'hAAA, 12'hAAA); // 20
        add_vec(12'd300,  12'd50,  11'd347,  11'd113,  1'b0, 1'b0, 12'hAAA, 12'hF0F); // 21
        add_vec(12'd300,  12'd50,  11'd348,  11'd113,  1'b0, 1'b0, 12'hBBB, 12'hBBB); // 22
        // Far-out position: nothing drawn, no wrap to the origin.
        add_vec(12'hFFF,  12'hFFF, 11'd0,    11'd770,  1'b0, 1'b1, 12'hCCC, 12'h000); // 23
        add_vec(12'hFFF,  12'hFFF, 11'd0,    11'd0,    1'b0, 1'b0, 12'hCCC, 12'hCCC); // 24
        add_vec(12'hFFF,  12'hFFF, 11'd2047, 11'd2047, 1'b0, 1'b0, 12'hCCC, 12'hCCC); // 25
        add_vec(12'hFFF,  12'hFFF, 11'd47,   11'd63,   1'b0, 1'b0, 12'hDDD, 12'hDDD); // 26
        add_vec(12'hFFF,  12'hFFF, 11'd1023, 11'd767,  1'b0, 1'b0, 12'hDDD, 12'hDDD); // 27
        // Partly off-screen rectangle at (1000,700): clipped, still drawn.
        add_vec(12'd1000, 12'd700, 11'd0,    11'd770,  1'b0, 1'b1, 12'hEEE, 12'h000); // 28
        add_vec(12'd1000, 12'd700, 11'd1023, 11'd763,  1'b0, 1'b0, 12'hEEE, 12'hF0F); // 29
        add_vec(12'd1000, 12'd700, 11'd999,  11'd763,  1'b0, 1'b0, 12'hEEE, 12'hEEE); // 30
        add_vec(12'd1000, 12'd700, 11'd1023, 11'd699,  1'b0, 1'b0, 12'hEEE, 12'hEEE); // 31

        // ---- reset state ----
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // ---- async reset mid-line ----
        rst = 1'b0;
        a = '{xp: 12'd0, yp: 12'd0, h: 11'd500, v: 11'd500, hb: 1'b0, vb: 1'b0,
              rgb: 12'hABC, exp_rgb: 12'hABC};
        drive(a);
        repeat (3) @(negedge clk);
        check("pre-reset rgb_out", 64'(bus.rgb_out), 64'hABC);
        check("pre-reset hcount_out", 64'(bus.hcount_out), 64'd500);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        check_all_zero("held reset");
        rst = 1'b0;
        drive_idle();

        // ---- table stream, one pixel per clock ----
        n = vecs.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = vecs[i-2];
                check($sformatf("rgb_out vec%0d", i - 2), 64'(bus.rgb_out), 64'(e.exp_rgb));
                check($sformatf("timing_out vec%0d", i - 2),
                      64'({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
                           bus.hblnk_out, bus.vblnk_out}),
                      64'({e.h, e.v, e.h[3], e.v[0], e.hb, e.vb}));
            end
            if (i < n) begin
                drive(vecs[i]);
            end else begin
                drive_idle();
            end
        end

        // ---- alignment: one line with an hsync pulse, random colours ----
        // Latched rectangle is (1000,700); line 900 lies outside it.
        for (int i = 0; i < 202; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                if (exp_q.size() == 0) begin
                    check("align queue empty", 64'd0, 64'd1);
                end else begin
                    exp_w = exp_q.pop_front();
                    check($sformatf("align cycle %0d", i - 2),
                          64'({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
                               bus.hblnk_out, bus.vblnk_out, bus.rgb_out}),
                          64'(exp_w));
                end
            end
            if (i < 200) begin
                r = 12'($urandom_range(0, 4095));
                bus.xpos      = 12'd1000;
                bus.ypos      = 12'd700;
                bus.hcount_in = 11'(i);
                bus.vcount_in = 11'd900;
                bus.hsync_in  = (i >= 20 && i < 26);
                bus.vsync_in  = 1'b0;
                bus.hblnk_in  = 1'b0;
                bus.vblnk_in  = 1'b0;
                bus.rgb_in    = r;
                exp_q.push_back({11'(i), 11'd900, (i >= 20 && i < 26), 1'b0, 1'b0, 1'b0, r});
            end else begin
                drive_idle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
